cart_mem_arb: RTL

- Shares the single external cartridge memory port (ROM/SDRAM behind the cart mapper) between two requesters: the MD 68k cart bus and the 32X SH2 cart window. Also schedules periodic memory refresh.
- Sits between the cart mapper outputs (ROM_A/ROM_RD/ROM_WRx) and the memory controller.
- Stretches each requester's bus cycle with a wait/ack signal until its access completes.

---
 rtl/cart_mem_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cart_mem_arb.sv
// Cartridge memory arbiter: MD 68k and 32X SH2 share one memory port.
// Periodic refresh is scheduled in between and can preempt when overdue.
module cart_mem_arb #(
  parameter int AW           = 23,
  parameter int REF_INT      = 384,
  parameter int REF_URGENT   = 64,
  parameter int MD_BURST_MAX = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] MD_A,
  input  logic [15:0]   MD_DI,
  input  logic          MD_RD,
  input  logic          MD_WRL,
  input  logic          MD_WRH,
  output logic [15:0]   MD_DO,
  output logic          MD_WAIT,
  input  logic [AW-1:0] SH_A,
  input  logic [15:0]   SH_DI,
  input  logic          SH_RD,
  input  logic          SH_WRL,
  input  logic          SH_WRH,
  output logic [15:0]   SH_DO,
  output logic          SH_ACK,
  output logic [AW-1:0] MEM_A,
  output logic [15:0]   MEM_DO,
  input  logic [15:0]   MEM_DI,
  output logic          MEM_RD,
  output logic          MEM_WE,
  output logic [1:0]    MEM_BE,
  output logic          MEM_REF,
  input  logic          MEM_ACK
);

  localparam int RW = (REF_INT > 1) ? $clog2(REF_INT) : 1;
  localparam int UW = $clog2(REF_URGENT + 1);
  localparam int BW = $clog2(MD_BURST_MAX + 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REF_INT - 1);
  localparam logic [UW-1:0] URG_MAX   = UW'(REF_URGENT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MD_BURST_MAX);

  typedef enum logic [1:0] {IDLE, MD_ACC, SH_ACC, REF} state_t;

  state_t state, state_nx;

  logic          md_any_q, md_pend, md_rd, md_wl, md_wh;
  logic [AW-1:0] md_a;
  logic [15:0]   md_d, md_do_r;
  logic          sh_any_q, sh_pend, sh_rd, sh_wl, sh_wh;
  logic [AW-1:0] sh_a;
  logic [15:0]   sh_d, sh_do_r;
  logic          sh_ack_r;
  logic [RW-1:0] ref_cnt;
  logic [UW-1:0] urg_cnt;
  logic          ref_pend;
  logic [BW-1:0] burst;

  logic md_any, md_new, sh_any, sh_new;
  logic ref_wrap, urgent, md_done, sh_done, ref_done;

  assign md_any   = MD_RD | MD_WRL | MD_WRH;
  assign sh_any   = SH_RD | SH_WRL | SH_WRH;
  assign md_new   = md_any & ~md_any_q;
  assign sh_new   = sh_any & ~sh_any_q;
  assign ref_wrap = (ref_cnt == REF_LAST);
  assign urgent   = ref_pend & (urg_cnt == URG_MAX);
  assign md_done  = (state == MD_ACC) & MEM_ACK;
  assign sh_done  = (state == SH_ACC) & MEM_ACK;
  assign ref_done = (state == REF) & MEM_ACK;

  // The 68k is held from the very cycle its strobe edge is seen
  assign MD_WAIT = ~RST & (md_new | md_pend);
  assign MD_DO   = md_do_r;
  assign SH_DO   = sh_do_r;
  assign SH_ACK  = sh_ack_r;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (urgent)
          state_nx = REF;
        else if (md_pend && (burst < BURST_MAX || !sh_pend))
          state_nx = MD_ACC;
        else if (sh_pend)
          state_nx = SH_ACC;
        else if (ref_pend)
          state_nx = REF;
      end
      default: if (MEM_ACK) state_nx = IDLE;
    endcase
  end

  always_comb begin
    MEM_A   = '0;
    MEM_DO  = '0;
    MEM_RD  = 1'b0;
    MEM_WE  = 1'b0;
    MEM_BE  = 2'b00;
    MEM_REF = 1'b0;
    unique case (state)
      MD_ACC: begin
        MEM_A  = md_a;
        MEM_DO = md_d;
        MEM_RD = md_rd;
        MEM_WE = md_wl | md_wh;
        MEM_BE = md_rd ? 2'b11 : {md_wh, md_wl};
      end
      SH_ACC: begin
        MEM_A  = sh_a;
        MEM_DO = sh_d;
        MEM_RD = sh_rd;
        MEM_WE = sh_wl | sh_wh;
        MEM_BE = sh_rd ? 2'b11 : {sh_wh, sh_wl};
      end
      REF:     MEM_REF = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == MD_ACC) begin
        if (burst != BURST_MAX) burst <= burst + 1'b1;
      end else if (state == IDLE && state_nx != IDLE) begin
        burst <= '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      md_any_q <= 1'b0;
      md_pend  <= 1'b0;
      md_a     <= '0;
      md_d     <= '0;
      md_rd    <= 1'b0;
      md_wl    <= 1'b0;
      md_wh    <= 1'b0;
      md_do_r  <= '0;
    end else begin
      md_any_q <= md_any;
      if (md_new && !md_pend) begin
        md_pend <= 1'b1;
        md_a    <= MD_A;
        md_d    <= MD_DI;
        md_rd   <= MD_RD;
        md_wl   <= MD_WRL;
        md_wh   <= MD_WRH;
      end else if (md_done) begin
        md_pend <= 1'b0;
        if (md_rd) md_do_r <= MEM_DI;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_any_q <= 1'b0;
      sh_pend  <= 1'b0;
      sh_a     <= '0;
      sh_d     <= '0;
      sh_rd    <= 1'b0;
      sh_wl    <= 1'b0;
      sh_wh    <= 1'b0;
      sh_do_r  <= '0;
      sh_ack_r <= 1'b0;
    end else begin
      sh_any_q <= sh_any;
      sh_ack_r <= sh_done;
      if (sh_new && !sh_pend) begin
        sh_pend <= 1'b1;
        sh_a    <= SH_A;
        sh_d    <= SH_DI;
        sh_rd   <= SH_RD;
        sh_wl   <= SH_WRL;
        sh_wh   <= SH_WRH;
      end else if (sh_done) begin
        sh_pend <= 1'b0;
        if (sh_rd) sh_do_r <= MEM_DI;
      end
    end
  end

  // A wrap while a refresh is already owed is absorbed into that one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_cnt  <= '0;
      urg_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_done) begin
        ref_pend <= ref_wrap;
        urg_cnt  <= '0;
      end else begin
        if (ref_wrap) ref_pend <= 1'b1;
        if (ref_pend && urg_cnt != URG_MAX) urg_cnt <= urg_cnt + 1'b1;
      end
    end
  end

endmodule
